// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 matrix keypad scanner.
package keypad_pkg;

   localparam int unsigned ROWS  = 4;
   localparam int unsigned COLS  = 3;
   localparam int unsigned KEY_W = 4;
   localparam int unsigned ROW_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } kp_state_t;

   // Column index of a one-hot column vector; non-one-hot inputs map to 0.
   function automatic logic [1:0] col_idx(input logic [2:0] c);
      logic [1:0] idx;
      case (c)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic is_onehot3(input logic [2:0] c);
      return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// Free-running prescaler producing one scan tick every 2^DIV_W enabled cycles.
module scan_tick_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic fin,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   logic [DIV_W-1:0] cnt_q;

   always_ff @(posedge fin) begin
      if (rst)
         cnt_q <= '0;
      else if (enable)
         cnt_q <= cnt_q + DIV_W'(1);
   end

   assign tick = (&cnt_q) & enable;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: press/release debounce and a valid/ready key register.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEB_CNT = 4
) (
   input  logic             fin,
   input  logic             rst,
   input  logic             enable,
   input  logic [2:0]       colum,
   output logic [ROWS-1:0]  scan,
   output logic [KEY_W-1:0] keycode,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CNT);

   logic             tick;
   logic [2:0]       col_m, col_s;
   kp_state_t        state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] rel_q, rel_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [2:0]       cand_col_q, cand_col_d;
   logic             push;
   logic [KEY_W-1:0] push_key;

   scan_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .fin    (fin),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   assign scan = enable ? (4'b0001 << row_q) : 4'b0000;

   // Synchronizer and FSM state registers
   always_ff @(posedge fin) begin
      if (rst) begin
         col_m      <= '0;
         col_s      <= '0;
         state_q    <= SCAN;
         row_q      <= '0;
         deb_q      <= '0;
         rel_q      <= '0;
         cand_q     <= '0;
         cand_col_q <= '0;
      end else begin
         col_m      <= colum;
         col_s      <= col_m;
         state_q    <= state_d;
         row_q      <= row_d;
         deb_q      <= deb_d;
         rel_q      <= rel_d;
         cand_q     <= cand_d;
         cand_col_q <= cand_col_d;
      end
   end

   // Next state; everything advances only on a scan tick
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      deb_d      = deb_q;
      rel_d      = rel_q;
      cand_d     = cand_q;
      cand_col_d = cand_col_q;
      push       = 1'b0;
      push_key   = cand_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (is_onehot3(col_s)) begin
                  cand_d     = {col_idx(col_s), row_q};
                  cand_col_d = col_s;
                  deb_d      = CNT_W'(1);
                  push_key   = {col_idx(col_s), row_q};
                  if (DEB_LIM == CNT_W'(1)) begin
                     push    = 1'b1;
                     rel_d   = '0;
                     state_d = HELD;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
            DEBOUNCE: begin
               if (col_s == cand_col_q) begin
                  deb_d = deb_q + CNT_W'(1);
                  if (deb_d == DEB_LIM) begin
                     push    = 1'b1;
                     rel_d   = '0;
                     state_d = HELD;
                  end
               end else begin
                  state_d = SCAN;
               end
            end
            HELD: begin
               if (col_s == 3'b000) begin
                  rel_d = rel_q + CNT_W'(1);
                  if (rel_d == DEB_LIM) begin
                     row_d   = row_q + ROW_W'(1);
                     state_d = SCAN;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // Output key register: a push while an unconsumed key sits here is dropped
   always_ff @(posedge fin) begin
      if (rst) begin
         keycode   <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (push) begin
            if (!key_valid || key_ready) begin
               keycode   <= push_key;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized scoreboard bench for keypad_scan_ctrl against a tick-level keypad model.
module tb_keypad_scan_ctrl;

   localparam int unsigned DIV_W   = 2;
   localparam int unsigned DEB_CNT = 3;
   localparam int          NCYC    = 20000;

   logic       fin = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] colum;
   logic [3:0] scan;
   logic [3:0] keycode;
   logic       key_valid;
   logic       key_ready;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int n_xfer   = 0;
   int exp_q[$];

   // Behavioural model: prescaler phase, scanned row, key phase (0 idle, 1 confirming, 2 held)
   int m_p, m_row, m_phase, m_run, m_col;
   bit m_valid, m_ovr, m_tick_prev;

   always #5 fin = ~fin;

   keypad_scan_ctrl #(.DIV_W(DIV_W), .DEB_CNT(DEB_CNT)) dut (
      .fin       (fin),
      .rst       (rst),
      .enable    (enable),
      .colum     (colum),
      .scan      (scan),
      .keycode   (keycode),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overrun   (overrun)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int key_of(input int c, input int r);
      int idx;
      idx = (c == 1) ? 0 : ((c == 2) ? 1 : 2);
      return idx * 4 + r;
   endfunction

   task automatic model_reset();
      m_p = 0; m_row = 0; m_phase = 0; m_run = 0; m_col = 0;
      m_valid = 0; m_ovr = 0; m_tick_prev = 0;
      exp_q.delete();
   endtask

   // One scan tick seen by a human-level keypad: confirm a press, then wait for a quiet release
   task automatic model_tick(input int c, output bit push, output int key);
      push = 0;
      key  = 0;
      case (m_phase)
         0: begin
            if ($countones(c) == 1) begin
               m_col = c;
               m_run = 1;
               if (m_run >= int'(DEB_CNT)) begin
                  push = 1; key = key_of(m_col, m_row); m_phase = 2; m_run = 0;
               end else begin
                  m_phase = 1;
               end
            end else begin
               m_row = (m_row + 1) % 4;
            end
         end
         1: begin
            if (c == m_col) begin
               m_run++;
               if (m_run == int'(DEB_CNT)) begin
                  push = 1; key = key_of(m_col, m_row); m_phase = 2; m_run = 0;
               end
            end else begin
               m_phase = 0;
            end
         end
         default: begin
            if (c == 0) begin
               m_run++;
               if (m_run == int'(DEB_CNT)) begin
                  m_phase = 0;
                  m_row   = (m_row + 1) % 4;
               end
            end else begin
               m_run = 0;
            end
         end
      endcase
   endtask

   // Advance the model across the coming clock edge using the inputs just driven
   task automatic model_step();
      bit push;
      int key;
      m_ovr       = 0;
      m_tick_prev = 0;
      push        = 0;
      key         = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (enable) begin
         if (m_p == 3) begin
            m_tick_prev = 1;
            model_tick(int'(colum), push, key);
         end
         m_p = (m_p + 1) % 4;
      end
      if (push) begin
         if (!m_valid || key_ready) begin
            exp_q.push_back(key);
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && key_ready) begin
         m_valid = 0;
      end
   endtask

   // Monitor: every accepted transfer must carry the next expected key
   initial begin
      forever begin
         @(negedge fin);
         #1;
         if (!rst && key_valid === 1'b1 && key_ready === 1'b1) begin
            n_xfer++;
            if (exp_q.size() == 0)
               check("xfer_unexpected", 1, 0);
            else
               check("keycode", int'(keycode), exp_q.pop_front());
         end
      end
   end

   initial begin
      int rst_left = 0;
      int en_off   = 0;
      int r;
      rst       = 1'b1;
      enable    = 1'b1;
      colum     = 3'b000;
      key_ready = 1'b0;
      model_reset();

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge fin);
         check("scan", int'(scan), enable ? (1 << m_row) : 0);
         check("key_valid", int'(key_valid), int'(m_valid));
         check("overrun", int'(overrun), int'(m_ovr));

         if (cyc < 2) begin
            rst = 1'b1;
         end else if (rst_left > 0) begin
            rst = 1'b1;
            rst_left--;
         end else begin
            rst = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
               rst      = 1'b1;
               rst_left = 1;
            end
         end

         if (en_off > 0) begin
            enable = 1'b0;
            en_off--;
         end else begin
            enable = 1'b1;
            if (cyc > 100 && $urandom_range(0, 99) == 0)
               en_off = $urandom_range(1, 12);
         end

         key_ready = ((cyc % 3000) < 700) ? 1'b0 : ($urandom_range(0, 2) != 0);

         // Column changes only just after a tick so they settle before the next one
         if (m_tick_prev) begin
            r = $urandom_range(0, 99);
            if (r < 70)
               colum = colum;
            else if (r < 82)
               colum = 3'b000;
            else if (r < 95)
               colum = 3'(1 << $urandom_range(0, 2));
            else
               colum = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b101;
         end

         model_step();
      end

      check("saw_transfers", int'(n_xfer > 0), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the 4-row × 3-column matrix keypad. It generates the row-scan tick from `fin` and drives the one-hot row strobe. It debounces both key press and key release, then delivers each accepted key exactly once through a valid/ready register. It replaces free-running scan and edge-pulse logic, and feeds downstream consumers such as the display and entry FSMs.

## Interface
- `DIV_W`, default 16: scan tick period is 2^DIV_W `fin` cycles.
- `DEB_CNT`, default 4: number of consecutive qualifying ticks that confirm a press, and separately a release (range 1–15).
- `fin`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous to `fin`, active-high.
- `enable`, in, 1: scan enable.
- `colum`, in, 3: column sense lines; asynchronous, active-high.
- `scan`, out, 4: one-hot row strobe; row r drives bit r.
- `keycode`, out, 4: accepted key, encoded {col_idx[1:0], row[1:0]}; col0 maps to 0–3, col1 to 4–7, col2 to 8–11.
- `key_valid`, out, 1: `keycode` holds an unconsumed key.
- `key_ready`, in, 1: consumer accepts the key.
- `overrun`, out, 1: one-cycle pulse when an accepted key is dropped.

## Operation
- **Synchronizer:** `colum` passes through a 2-flop synchronizer; all decisions below use the synchronized value `col_s`.
- **Prescaler:**
  - DIV_W-bit counter increments every cycle while `enable`=1 and holds while `enable`=0.
  - `tick` = counter all-ones AND `enable`.
- **Row counter:** 2-bit row index `row`.
  - `scan` = 1<<row when `enable`=1; `scan` = 4'b0000 when `enable`=0.
- **FSM, evaluated only on `tick` (state held otherwise):**
  - **SCAN**
    - `col_s`=000 or multi-hot (ghosting): row advances, 3 wraps to 0.
    - `col_s` single-hot: latch cand={idx(col_s),row} and cand_col=`col_s`; set deb=1; go to DEBOUNCE. Row is frozen.
    - If DEB_CNT=1, the press is accepted immediately and the FSM goes to HELD.
  - **DEBOUNCE**
    - `col_s`==cand_col: deb++.
    - When deb reaches DEB_CNT: push cand, clear rel, go to HELD.
    - `col_s`≠cand_col: return to SCAN; row is not advanced on this tick.
  - **HELD**
    - `col_s`=000: rel++.
    - Any nonzero `col_s`: rel=0.
    - rel reaches DEB_CNT: advance row, go to SCAN.
    - Exactly one push per press, however long the key is held.
- **Output register, on push:**
  - If `key_valid`=0, or `key_valid`=1 and `key_ready`=1 in the same cycle: keycode←cand and `key_valid`←1.
  - Otherwise the new key is dropped, `keycode` is unchanged, and `overrun`=1 for that cycle.
- **Handshake:**
  - A transfer occurs on a cycle where `key_valid` and `key_ready` are both 1.
  - `key_valid` falls on the next cycle unless a push occurs in the same cycle.
  - `keycode` is stable while `key_valid`=1.
  - `key_ready` while `key_valid`=0 is ignored.
- **Enable:**
  - `enable`=0 freezes FSM, row, deb and rel.
  - The handshake stays live while `enable`=0.
  - Resuming `enable` continues from the frozen state.

## Timing
- **Reset values:** state SCAN, row=0, prescaler=0, deb=rel=0.
  - `scan`=4'b0001 if `enable`=1, else 0000.
  - `keycode`=0, `key_valid`=0, `overrun`=0, synchronizer flops=0.
- **Reset mid-operation:**
  - A pending key is discarded.
  - A key still physically held is re-detected from SCAN and accepted again after DEB_CNT ticks.
- **Latency:**
  - `colum` to `col_s`: 2 cycles.
  - Push happens on the DEB_CNT-th qualifying tick, counting the first-detect tick as 1.
  - `key_valid` rises the cycle after push.
- **Rates:**
  - Minimum press-to-next-press spacing is 2·DEB_CNT ticks.
  - A row with no key stays strobed for exactly one tick period.

## Structure
- **Package `keypad_pkg`:**
  - FSM state enum {SCAN, DEBOUNCE, HELD}.
  - Constants ROWS=4, COLS=3, KEY_W=4.
  - Function col_idx(3-bit one-hot) → 2-bit index.
  - Function is_onehot3.
- **Sub-module `scan_tick_gen`:** prescaler plus enable gating, output `tick`.
- **Top module holds:** synchronizer, FSM, row counter, output register.

## Test plan
All directed tests use DIV_W=2 (tick every 4 cycles) and DEB_CNT=3.
- **Reset/idle:** `rst` high for 2 cycles, then `enable`=1 and `colum`=000 → `scan` sequence 0001, 0010, 0100, 1000, 0001, changing every 4 cycles; `key_valid`=0.
- **Clean press:** assert `colum`=010 while `scan`=0100 and hold for 40 cycles; `key_ready`=1 → exactly one transfer with `keycode`=6; `scan` frozen at 0100 until 3 zero ticks after release.
- **Bounce:** `colum`=001 on row 3 for 1 tick, then 000, then 001 again → no push on the first attempt; after 3 stable ticks `keycode`=3 is delivered once.
- **Backpressure/overrun:** `key_ready`=0; press key 0, release, then press key 9 → `keycode` stays 0 with `key_valid`=1; `overrun` pulses once for the dropped key; after `key_ready`=1 for one cycle, `key_valid`=0.
- **Ghost and enable:** `colum`=011 → rows keep advancing and no push occurs; dropping `enable` mid-DEBOUNCE gives `scan`=0000 and holds state; re-enabling completes the debounce and delivers the key.
- **Reset mid-key:** assert `rst` while in HELD with `key_valid`=1 → `key_valid`=0 the next cycle; with the key still held, it is re-accepted 3 ticks later.
